instruction_cache: RTL

Direct-mapped, read-only instruction cache between the 8-bit single-cycle CPU's PC/INSTRUCTION port and a slow 128-bit-line instruction memory. On a hit it returns the 32-bit instruction combinationally in the same cycle. On a miss it asserts BUSYWAIT to stall the CPU's PC update and fetches the 16-byte block from memory. It then installs the block and releases the stall.

---
 rtl/instruction_cache_pkg.sv | 17 +
 rtl/instruction_cache_if.sv | 22 ++
 rtl/icache_array.sv | 48 ++++
 rtl/instruction_cache.sv | 92 +++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// address field positions and line/word geometry.
package instruction_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_READ,
        ST_UPDATE
    } state_e;

    localparam int LINE_W    = 128;
    localparam int WORD_W    = 32;
    localparam int WORD_LSB  = 2;
    localparam int WORD_BITS = 2;
    localparam int BLOCK_LSB = 4;

endpackage

// File: rtl/instruction_cache_if.sv
// CPU fetch port plus instruction-memory block port, as seen by the cache.
interface instruction_cache_if #(
    parameter int ADDR_BITS = 10
);
    logic [31:0]            PC;
    logic [31:0]            INSTRUCTION;
    logic                   BUSYWAIT;
    logic                   MEM_READ;
    logic [ADDR_BITS-5:0]   MEM_ADDRESS;
    logic [127:0]           MEM_READDATA;
    logic                   MEM_BUSYWAIT;

    modport slave (
        input  PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port and one synchronous fill port.
// Only the valid bits are cleared by reset; tags and data keep stale contents.
module icache_array
    import instruction_cache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    input  logic [WORD_BITS-1:0]  rd_word_i,
    output logic                  rd_hit_o,
    output logic [WORD_W-1:0]     rd_data_o,
    input  logic                  fill_en_i,
    input  logic [INDEX_BITS-1:0] fill_index_i,
    input  logic [TAG_BITS-1:0]   fill_tag_i,
    input  logic [LINE_W-1:0]     fill_data_i
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]               valid_q;
    logic [LINES-1:0][TAG_BITS-1:0] tag_q;
    logic [LINES-1:0][LINE_W-1:0]   data_q;
    logic                           fill_ok;

    // Reset wins over a fill landing on the same edge.
    assign fill_ok = fill_en_i && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET)
            valid_q <= '0;
        else if (fill_ok)
            valid_q[fill_index_i] <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (fill_ok) begin
            tag_q[fill_index_i]  <= fill_tag_i;
            data_q[fill_index_i] <= fill_data_i;
        end
    end

    assign rd_hit_o  = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_index_i][rd_word_i*WORD_W +: WORD_W];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, stalls the CPU
// and fetches a whole 16-byte block from memory on a miss.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_BITS  = 10
) (
    input  logic                CLK,
    input  logic                RESET,
    instruction_cache_if.slave  bus
);
    localparam int BLK_BITS = ADDR_BITS - BLOCK_LSB;
    localparam int TAG_BITS = BLK_BITS - INDEX_BITS;

    state_e                state_q, state_d;
    logic [BLK_BITS-1:0]   miss_q, miss_d;
    logic [BLK_BITS-1:0]   pc_blk;
    logic                  hit;
    logic                  fill_en;
    logic                  busy;
    logic                  mem_read;
    logic                  unused_pc;

    assign pc_blk    = bus.PC[ADDR_BITS-1:BLOCK_LSB];
    assign unused_pc = ^{bus.PC[31:ADDR_BITS], bus.PC[WORD_LSB-1:0]};

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .CLK          (CLK),
        .RESET        (RESET),
        .rd_index_i   (pc_blk[INDEX_BITS-1:0]),
        .rd_tag_i     (pc_blk[BLK_BITS-1:INDEX_BITS]),
        .rd_word_i    (bus.PC[BLOCK_LSB-1:WORD_LSB]),
        .rd_hit_o     (hit),
        .rd_data_o    (bus.INSTRUCTION),
        .fill_en_i    (fill_en),
        .fill_index_i (miss_q[INDEX_BITS-1:0]),
        .fill_tag_i   (miss_q[BLK_BITS-1:INDEX_BITS]),
        .fill_data_i  (bus.MEM_READDATA)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        busy     = 1'b0;
        mem_read = 1'b0;
        fill_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hit) begin
                    busy    = 1'b1;
                    miss_d  = pc_blk;
                    state_d = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!bus.MEM_BUSYWAIT) begin
                    fill_en = 1'b1;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                // One extra stall cycle lets INSTRUCTION settle from the new line.
                busy    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (RESET)
            busy = 1'b0;
    end

    assign bus.BUSYWAIT    = busy;
    assign bus.MEM_READ    = mem_read;
    assign bus.MEM_ADDRESS = miss_q;

endmodule
